// File: rtl/frame_pkg.sv
// Shared types and helpers for the multi-channel frame packer.
// State encodings are one-hot; bit order matches dp_status (PAD sits in bit 9).
package frame_pkg;

  typedef enum logic [9:0] {
    S_IDLE  = 10'h001,
    S_HDR   = 10'h002,
    S_ID    = 10'h004,
    S_WAIT  = 10'h008,
    S_SHIFT = 10'h010,
    S_WR    = 10'h020,
    S_FRM   = 10'h040,
    S_CHK   = 10'h080,
    S_TAIL  = 10'h100,
    S_PAD   = 10'h200
  } state_e;

  localparam logic [15:0] ID_MAGIC = 16'h55AA;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pix_word_packer.sv
// Holds one strobe's channel pixels and packs them little-endian into an OUT_W accumulator.
module pix_word_packer
  import frame_pkg::*;
#(
  parameter int N_CH  = 1,
  parameter int PIX_W = 16,
  parameter int OUT_W = 32
) (
  input  logic                  clk_200m,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  pad_i,
  input  logic                  clear_i,
  input  logic [N_CH*PIX_W-1:0] stage_i,
  output logic [OUT_W-1:0]      acc_o,
  output logic                  fills_o,
  output logic                  last_o,
  output logic                  ch_left_o
);

  localparam int PACK = OUT_W / PIX_W;
  localparam int CW   = clog2(N_CH + 1);
  localparam int FW   = clog2(PACK + 1);

  logic [N_CH*PIX_W-1:0] stage_q, stage_d;
  logic [CW-1:0]         ch_idx_q, ch_idx_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [PIX_W-1:0]      pix;

  always_comb begin
    pix = '0;
    for (int c = 0; c < N_CH; c++)
      if (ch_idx_q == CW'(c)) pix = stage_q[c*PIX_W +: PIX_W];
  end

  always_comb begin
    stage_d  = stage_q;
    ch_idx_d = ch_idx_q;
    acc_d    = acc_q;
    fill_d   = fill_q;
    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end
    if (load_i) begin
      stage_d  = stage_i;
      ch_idx_d = '0;
    end
    if (shift_i) begin
      for (int f = 0; f < PACK; f++)
        if (fill_q == FW'(f)) acc_d[f*PIX_W +: PIX_W] = pix;
      fill_d   = fill_q + 1'b1;
      ch_idx_d = ch_idx_q + 1'b1;
    end
    // Upper slots are already zero since the accumulator is cleared on every emit.
    if (pad_i) fill_d = FW'(PACK);
  end

  always_ff @(posedge clk_200m) begin
    if (reset) begin
      stage_q  <= '0;
      ch_idx_q <= '0;
      acc_q    <= '0;
      fill_q   <= '0;
    end else begin
      stage_q  <= stage_d;
      ch_idx_q <= ch_idx_d;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
    end
  end

  assign acc_o     = acc_q;
  assign fills_o   = (fill_q == FW'(PACK - 1));
  assign last_o    = (ch_idx_q == CW'(N_CH - 1));
  assign ch_left_o = (ch_idx_q != CW'(N_CH));

endmodule

// File: rtl/frame_packer_mc.sv
// Frames N_CH-channel pixel strobes as header, ID, payload, frame number, checksum, tail.
// States: IDLE HDR ID WAIT SHIFT WR FRM CHK TAIL (dp_status bits 0..8); PAD reports as SHIFT.
module frame_packer_mc
  import frame_pkg::*;
#(
  parameter int N_CH          = 1,
  parameter int PIX_W         = 16,
  parameter int OUT_W         = 32,
  parameter int PIX_PER_FRAME = 5184,
  parameter int CHK_EN        = 1
) (
  input  logic                  clk_200m,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic                  trans_start,
  input  logic                  aligned,
  input  logic [N_CH*PIX_W-1:0] input_data,
  input  logic [3:0]            board_number,
  input  logic [3:0]            chip_number,
  input  logic [31:0]           header,
  input  logic [31:0]           tail,
  input  logic                  fifo_full,
  output logic                  fifo_wren,
  output logic [OUT_W-1:0]      out_data,
  output logic [31:0]           frame_num,
  output logic [15:0]           overrun_cnt,
  output logic [8:0]            dp_status
);

  state_e           state_q, state_d;
  logic [1:0]       al_q, dv_q;
  logic             wren_q, wren_d;
  logic [OUT_W-1:0] out_q, out_d, chk_q, chk_d, acc;
  logic [31:0]      frame_q, frame_d;
  logic [15:0]      pix_q, pix_d, ovr_q, ovr_d;
  logic             load, shift, pad, clear;
  logic             fills, last, ch_left;
  logic             aligned_s, strobe, last_pix;
  logic [9:0]       st_bits;

  assign aligned_s = al_q[1];
  assign strobe    = dv_q[0] & ~dv_q[1];
  assign last_pix  = (pix_q == 16'(PIX_PER_FRAME));

  pix_word_packer #(.N_CH(N_CH), .PIX_W(PIX_W), .OUT_W(OUT_W)) u_packer (
    .clk_200m (clk_200m),
    .reset    (reset),
    .load_i   (load),
    .shift_i  (shift),
    .pad_i    (pad),
    .clear_i  (clear),
    .stage_i  (input_data),
    .acc_o    (acc),
    .fills_o  (fills),
    .last_o   (last),
    .ch_left_o(ch_left)
  );

  always_comb begin
    state_d = state_q;
    wren_d  = 1'b0;
    out_d   = out_q;
    frame_d = frame_q;
    pix_d   = pix_q;
    chk_d   = chk_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    shift   = 1'b0;
    pad     = 1'b0;
    clear   = 1'b0;

    if (strobe && (state_q inside {S_SHIFT, S_PAD, S_WR}) && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (trans_start) frame_d = '0;
        else if (aligned_s) state_d = S_HDR;
      end
      S_HDR: if (!fifo_full) begin
        wren_d  = 1'b1;
        out_d   = OUT_W'(header);
        state_d = S_ID;
      end
      S_ID: if (!fifo_full) begin
        wren_d  = 1'b1;
        out_d   = OUT_W'({ID_MAGIC, 4'd0, board_number, 4'd0, chip_number});
        state_d = S_WAIT;
      end
      S_WAIT: if (strobe) begin
        load    = 1'b1;
        pix_d   = pix_q + 16'd1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (fills) state_d = S_WR;
        else if (last) state_d = last_pix ? S_PAD : S_WAIT;
      end
      S_PAD: begin
        pad     = 1'b1;
        state_d = S_WR;
      end
      S_WR: if (!fifo_full) begin
        wren_d = 1'b1;
        out_d  = acc;
        chk_d  = chk_q ^ acc;
        clear  = 1'b1;
        if (ch_left) state_d = S_SHIFT;
        else if (last_pix) state_d = S_FRM;
        else state_d = S_WAIT;
      end
      S_FRM: if (!fifo_full) begin
        wren_d  = 1'b1;
        out_d   = OUT_W'(frame_q + 32'd1);
        frame_d = frame_q + 32'd1;
        state_d = (CHK_EN != 0) ? S_CHK : S_TAIL;
      end
      S_CHK: if (!fifo_full) begin
        wren_d  = 1'b1;
        out_d   = chk_q;
        state_d = S_TAIL;
      end
      S_TAIL: if (!fifo_full) begin
        wren_d  = 1'b1;
        out_d   = OUT_W'(tail);
        pix_d   = '0;
        chk_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_200m) begin
    if (reset) begin
      state_q <= S_IDLE;
      al_q    <= '0;
      dv_q    <= '0;
      wren_q  <= 1'b0;
      out_q   <= '0;
      frame_q <= '0;
      pix_q   <= '0;
      chk_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      al_q    <= {al_q[0], aligned};
      dv_q    <= {dv_q[0], data_valid};
      wren_q  <= wren_d;
      out_q   <= out_d;
      frame_q <= frame_d;
      pix_q   <= pix_d;
      chk_q   <= chk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign st_bits     = state_q;
  assign dp_status   = st_bits[8:0] | {4'b0, st_bits[9], 4'b0};
  assign fifo_wren   = wren_q;
  assign out_data    = out_q;
  assign frame_num   = frame_q;
  assign overrun_cnt = ovr_q;

endmodule
